fsquare_seq: RTL and testbench

- Multi-cycle single-precision square unit, y = x1 * x1. It is the inverse-direction companion of the combinational fsqrt datapath.
- It is used by the FPU verification/self-check path and by software-visible fsquare ops to reconstruct operands from fsqrt results.
- Mantissa product is a radix-2 shift-add over 24 cycles, followed by one normalise/round cycle.
- Valid/ready handshakes on both input and output.

---
 rtl/fsquare_seq_if.sv | 20 ++
 rtl/fsquare_seq.sv | 128 ++++++++++++
 tb/tb_fsquare_seq.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/fsquare_seq_if.sv
// Operand/result handshake bundle for the sequential single-precision squarer.
// The master drives the operand and result-ready; the slave returns the result.
interface fsquare_seq_if;
  logic [31:0] x1;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] y;
  logic        valid_out;
  logic        ready_out;

  modport master (
    output x1, valid_in, ready_out,
    input  ready_in, y, valid_out
  );

  modport slave (
    input  x1, valid_in, ready_out,
    output ready_in, y, valid_out
  );
endinterface

// File: rtl/fsquare_seq.sv
// Multi-cycle IEEE-754 single-precision square, y = x1*x1, via 24-step shift-add.
// Accept -> MUL(24) -> NORM(1) -> DONE; valid_out rises 26 edges after accept.
module fsquare_seq #(
  parameter int unsigned MANT_W   = 23,
  parameter int unsigned EXP_BIAS = 127
) (
  input  logic          clk,
  input  logic          rstn,
  fsquare_seq_if.slave  bus
);

  localparam int unsigned SIG_W  = MANT_W + 1;
  localparam int unsigned PROD_W = 2 * SIG_W;
  localparam int unsigned CNT_W  = $clog2(SIG_W);
  localparam int unsigned OP_W   = 31;
  localparam int unsigned EXP_W  = 10;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM, S_DONE} state_t;

  state_t              r_state;
  logic [OP_W-1:0]     r_x;
  logic [PROD_W-1:0]   r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic [31:0]         r_y;
  logic                r_valid_out;
  logic                r_ready_in;

  logic [SIG_W-1:0]    w_ma;
  logic [7:0]          w_exp_in;
  logic [MANT_W-1:0]   w_frac_in;
  logic                w_p47;
  logic [MANT_W-1:0]   w_mant;
  logic                w_guard;
  logic                w_sticky;
  logic                w_rnd;
  logic [SIG_W-1:0]    w_mant_r;
  logic signed [EXP_W-1:0] w_e;
  logic signed [EXP_W-1:0] w_e_fin;
  logic [31:0]         w_y;
  logic                w_unused_sign;

  assign w_unused_sign = bus.x1[31];
  assign w_exp_in      = r_x[OP_W-1 -: 8];
  assign w_frac_in     = r_x[MANT_W-1:0];
  assign w_ma          = {1'b1, w_frac_in};

  assign bus.y         = r_y;
  assign bus.valid_out = r_valid_out;
  assign bus.ready_in  = r_ready_in;

  // Normalise, round-to-nearest-even and special-case selection on the finished product
  always_comb begin
    w_p47    = r_acc[PROD_W-1];
    w_mant   = r_acc[PROD_W-3 -: MANT_W];
    w_guard  = r_acc[PROD_W-3-MANT_W];
    w_sticky = |r_acc[PROD_W-4-MANT_W:0];
    w_e      = $signed({1'b0, w_exp_in, 1'b0}) - $signed(EXP_W'(EXP_BIAS));
    if (w_p47) begin
      w_mant   = r_acc[PROD_W-2 -: MANT_W];
      w_guard  = r_acc[PROD_W-2-MANT_W];
      w_sticky = |r_acc[PROD_W-3-MANT_W:0];
      w_e      = w_e + 10'sd1;
    end
    w_rnd    = w_guard & (w_sticky | w_mant[0]);
    w_mant_r = {1'b0, w_mant} + SIG_W'(w_rnd);
    w_e_fin  = w_e + (w_mant_r[MANT_W] ? 10'sd1 : 10'sd0);
    w_y      = {1'b0, w_e_fin[7:0], (w_mant_r[MANT_W] ? MANT_W'(0) : w_mant_r[MANT_W-1:0])};

    if (w_exp_in == 8'd0) begin
      w_y = 32'h0000_0000;
    end else if (w_exp_in == 8'hFF) begin
      w_y = (w_frac_in == '0) ? 32'h7F80_0000 : 32'h7FC0_0000;
    end else if (w_e_fin >= 10'sd255) begin
      w_y = 32'h7F80_0000;
    end else if (w_e_fin <= 10'sd0) begin
      w_y = 32'h0000_0000;
    end
  end

  // Control FSM; DONE spends one cycle letting y settle before valid_out is raised
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_y         <= '0;
      r_valid_out <= 1'b0;
      r_ready_in  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.valid_in && r_ready_in) begin
            r_x        <= bus.x1[OP_W-1:0];
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ready_in <= 1'b0;
            r_state    <= S_MUL;
          end
        end
        S_MUL: begin
          if (w_ma[r_cnt]) begin
            r_acc <= r_acc + (PROD_W'(w_ma) << r_cnt);
          end
          r_cnt <= CNT_W'(r_cnt + CNT_W'(1));
          if (r_cnt == CNT_W'(SIG_W - 1)) begin
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          r_y     <= w_y;
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (!r_valid_out) begin
            r_valid_out <= 1'b1;
          end else if (bus.ready_out) begin
            r_valid_out <= 1'b0;
            r_ready_in  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsquare_seq.sv
// Self-checking bench for fsquare_seq: directed cases, random sweep against a
// real-arithmetic square model, backpressure and mid-operation reset.
module tb_fsquare_seq;

  logic clk = 1'b0;
  logic rstn;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fsquare_seq_if bus ();

  fsquare_seq dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Square computed in real arithmetic, then rounded to single precision (RNE).
  function automatic logic [31:0] model_sq(input logic [31:0] x);
    int  e, m, k, fl;
    real f, sq, frac, rem;
    e = int'(x[30:23]);
    m = int'(x[22:0]);
    if (e == 0) return 32'h0000_0000;
    if (e == 255) return (m == 0) ? 32'h7F80_0000 : 32'h7FC0_0000;
    f  = 1.0 + m / 8388608.0;
    sq = f * f;
    k  = 2 * (e - 127);
    if (sq >= 2.0) begin
      sq = sq / 2.0;
      k++;
    end
    frac = (sq - 1.0) * 8388608.0;
    fl   = $rtoi(frac);
    rem  = frac - fl;
    if (rem > 0.5 || (rem == 0.5 && (fl % 2) == 1)) fl++;
    if (fl == 8388608) begin
      fl = 0;
      k++;
    end
    k = k + 127;
    if (k >= 255) return 32'h7F80_0000;
    if (k <= 0) return 32'h0000_0000;
    return {1'b0, 8'(k), 23'(fl)};
  endfunction

  // Send one operand with ready_out high; check latency, busy ready_in, result, release.
  task automatic run_op(input logic [31:0] x, input logic [31:0] exp_y, input string tag, input bit full);
    int lat;
    bit busy_ok;
    @(negedge clk);
    bus.x1        = x;
    bus.valid_in  = 1'b1;
    bus.ready_out = 1'b1;
    for (int i = 0; i < 60 && !bus.ready_in; i++) @(negedge clk);
    if (!bus.ready_in) check({tag, "_accept_timeout"}, 32'(bus.ready_in), 32'd1);
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    bus.x1       = $urandom;
    busy_ok = (bus.ready_in == 1'b0);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.valid_out) begin
        lat = k;
        break;
      end
      if (bus.ready_in) busy_ok = 1'b0;
    end
    check({tag, "_latency"}, 32'(lat), 32'd26);
    check({tag, "_y"}, bus.y, exp_y);
    if (full) begin
      check({tag, "_ready_in_busy"}, 32'(busy_ok), 32'd1);
      @(posedge clk);
      #1;
      check({tag, "_valid_drop"}, 32'(bus.valid_out), 32'd0);
      check({tag, "_ready_in_back"}, 32'(bus.ready_in), 32'd1);
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] dir_x [9];
    logic [31:0] dir_y [9];
    logic [31:0] x, held_y;
    int          lat;

    dir_x = '{32'h3F80_0000, 32'h4040_0000, 32'hC000_0000, 32'h3FC0_0000, 32'h3FFF_FFFF,
              32'h7F00_0000, 32'h1F80_0000, 32'h0040_0000, 32'h7F80_0001};
    dir_y = '{32'h3F80_0000, 32'h4110_0000, 32'h4080_0000, 32'h4010_0000, 32'h407F_FFFE,
              32'h7F80_0000, 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000};

    rstn          = 1'b0;
    bus.x1        = '0;
    bus.valid_in  = 1'b0;
    bus.ready_out = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_y", bus.y, 32'h0);
    check("rst_valid_out", 32'(bus.valid_out), 32'd0);
    check("rst_ready_in", 32'(bus.ready_in), 32'd1);
    rstn = 1'b1;

    for (int i = 0; i < 9; i++) run_op(dir_x[i], dir_y[i], $sformatf("dir%0d", i), 1'b1);

    // Backpressure: result held for 10 cycles while a competing operand is offered
    @(negedge clk);
    bus.ready_out = 1'b0;
    bus.x1        = 32'h4040_0000;
    bus.valid_in  = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.valid_out) begin
        lat = k;
        break;
      end
    end
    check("bp_latency", 32'(lat), 32'd26);
    check("bp_y", bus.y, 32'h4110_0000);
    held_y = bus.y;
    bus.x1       = 32'h3FC0_0000;
    bus.valid_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_hold_valid%0d", k), 32'(bus.valid_out), 32'd1);
      check($sformatf("bp_hold_y%0d", k), bus.y, held_y);
      check($sformatf("bp_hold_ready_in%0d", k), 32'(bus.ready_in), 32'd0);
    end
    @(negedge clk);
    bus.valid_in  = 1'b0;
    bus.ready_out = 1'b1;
    @(posedge clk);
    #1;
    check("bp_valid_fall", 32'(bus.valid_out), 32'd0);
    check("bp_ready_in_rise", 32'(bus.ready_in), 32'd1);
    check("bp_y_after", bus.y, 32'h4110_0000);

    // Reset in the middle of the multiply aborts the operation
    @(negedge clk);
    bus.x1       = 32'h3FC0_0000;
    bus.valid_in = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("mrst_valid_out", 32'(bus.valid_out), 32'd0);
    check("mrst_y", bus.y, 32'h0);
    check("mrst_ready_in", 32'(bus.ready_in), 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    run_op(32'h4000_0000, 32'h4080_0000, "mrst_two", 1'b1);

    // Random sweep over normal exponents, plus some zero/denormal/inf/nan operands
    for (int i = 0; i < 2000; i++) begin
      x = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
      run_op(x, model_sq(x), $sformatf("rnd%0d_%h", i, x), 1'b0);
    end
    for (int i = 0; i < 40; i++) begin
      x = {1'($urandom), (i % 2 == 0) ? 8'h00 : 8'hFF, (i % 4 < 2) ? 23'($urandom) : 23'h0};
      run_op(x, model_sq(x), $sformatf("spc%0d_%h", i, x), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
